// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in
// over a fixed window of GATE_CYCLES clk periods.
module freq_gate_counter #(
  parameter int CLK_FREQ_HZ = 2500000,
  parameter int GATE_CYCLES = CLK_FREQ_HZ,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq_out,
  output logic             overflow
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    LATCH
  } state_e;

  state_e state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic edge_w;

  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign edge_w = s2_q & ~s3_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      gcnt_q  <= '0;
      ecnt_q  <= '0;
      freq_q  <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      gcnt_q  <= gcnt_d;
      ecnt_q  <= ecnt_d;
      freq_q  <= freq_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    ecnt_d  = ecnt_q;
    freq_d  = freq_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ARM;
      end
      ARM: begin
        gcnt_d  = '0;
        ecnt_d  = '0;
        sat_d   = 1'b0;
        state_d = GATE;
      end
      GATE: begin
        gcnt_d = gcnt_q + 1'b1;
        // saturate instead of wrapping; a lost edge marks overflow
        if (edge_w) begin
          if (ecnt_q == CMAX) sat_d = 1'b1;
          else ecnt_d = ecnt_q + 1'b1;
        end
        if (gcnt_q == GLAST) state_d = LATCH;
      end
      LATCH: begin
        freq_d  = ecnt_q;
        ovf_d   = sat_q;
        done_d  = 1'b1;
        state_d = cont ? ARM : IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ARM) || (state_d == GATE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign freq_out = freq_q;
  assign overflow = ovf_q;

endmodule
